// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered binary-to-one-hot decoder with two modes.
//   DIRECT decodes one handshaked index per transfer.
//   SCAN   walks a one-hot pattern over indices 0..MAX_INDEX, one step every
//          SCAN_DIV clocks, pulsing o_wrap on the MAX_INDEX -> 0 step.
// Optional macro DEC_RANGE_ERR_EN adds a sticky o_err flag that records any
// DIRECT transfer whose index lies above MAX_INDEX.
module decoder_n_scan #(
  parameter int W_IN      = 2,
  parameter int MAX_INDEX = (1 << W_IN) - 1,
  parameter int SCAN_DIV  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mode,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [W_IN-1:0]        i_binary,
  output logic [(1<<W_IN)-1:0]   o_one_hot,
  output logic [W_IN-1:0]        o_index,
  output logic                   o_valid,
  output logic                   o_wrap
`ifdef DEC_RANGE_ERR_EN
  ,
  output logic                   o_err
`endif
);

  localparam int OUT_W = 1 << W_IN;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [W_IN-1:0] MAX_IDX    = W_IN'(MAX_INDEX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [W_IN-1:0]  index_q,   index_d;
  logic [OUT_W-1:0] one_hot_q, one_hot_d;
  logic             valid_q,   valid_d;
  logic             wrap_q,    wrap_d;
  logic [PW-1:0]    presc_q,   presc_d;
`ifdef DEC_RANGE_ERR_EN
  logic             err_q,     err_d;
`endif

  logic [OUT_W-1:0] in_dec;
  logic             in_range;
  logic [W_IN-1:0]  start_idx;
  logic [W_IN-1:0]  step_idx;

  // Out-of-range indices decode to all-zero, so the decoder itself doubles
  // as the range check: a nonzero result means the index is legal.
  function automatic logic [OUT_W-1:0] decode(input logic [W_IN-1:0] idx);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if ((k <= MAX_INDEX) && (idx == W_IN'(k))) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Decode the incoming index and derive scan start / next-step indices.
  always_comb begin
    in_dec    = decode(i_binary);
    in_range  = |in_dec;
    start_idx = in_range ? i_binary : '0;
    step_idx  = (index_q == MAX_IDX) ? '0 : index_q + 1'b1;
  end

  // Next-state logic for the mode FSM, prescaler and output registers.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    index_d   = index_q;
    one_hot_d = one_hot_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    presc_d   = presc_q;
`ifdef DEC_RANGE_ERR_EN
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          valid_d = 1'b1;
          if (!i_mode) begin
            index_d   = i_binary;
            one_hot_d = in_dec;
`ifdef DEC_RANGE_ERR_EN
            if (!in_range) err_d = 1'b1;
`endif
          end else begin
            index_d   = start_idx;
            one_hot_d = decode(start_idx);
            presc_d   = '0;
            state_d   = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (!i_mode) begin
          // Leaving SCAN freezes the outputs; no step happens on this edge.
          state_d = ST_IDLE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d   = '0;
          valid_d   = 1'b1;
          wrap_d    = (index_q == MAX_IDX);
          index_d   = step_idx;
          one_hot_d = decode(step_idx);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (i_rst) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      one_hot_q <= OUT_W'(1);
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      presc_q   <= '0;
`ifdef DEC_RANGE_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      one_hot_q <= one_hot_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      presc_q   <= presc_d;
`ifdef DEC_RANGE_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_one_hot = one_hot_q;
  assign o_index   = index_q;
  assign o_valid   = valid_q;
  assign o_wrap    = wrap_q;
`ifdef DEC_RANGE_ERR_EN
  assign o_err     = err_q;
`endif

endmodule
